// File: rtl/change_pkg.sv
// Shared types and helpers for the change-capture FIFO.
package change_pkg;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] mask;
  } entry_t;

  function automatic logic [WIDTH-1:0] toggle_mask(input logic [WIDTH-1:0] new_val,
                                                   input logic [WIDTH-1:0] old_val);
    return new_val ^ old_val;
  endfunction

endpackage

// File: rtl/change_capture_fifo_if.sv
// Monitored bus, consumer handshake and status outputs of the change-capture FIFO.
interface change_capture_fifo_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]         a;
  logic [2*WIDTH-1:0]       out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CNT_W-1:0]         change_cnt;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    input  a, out_ready,
    output out_data, out_valid, change_cnt, overflow, level
  );

  modport slave (
    output a, out_ready,
    input  out_data, out_valid, change_cnt, overflow, level
  );
endinterface

// File: rtl/change_capture_fifo_sync_fifo.sv
// First-word-fall-through FIFO; a push is accepted when full only if a pop frees a slot.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: stale words are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/change_capture_fifo.sv
// Watches a registered bus, queues {new value, toggle mask} per change, counts changes, flags drops.
module change_capture_fifo #(
  parameter int WIDTH = change_pkg::WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  change_capture_fifo_if.master bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               primed_q, primed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               chg_event, pop, drop, full, empty;
  change_pkg::entry_t entry;
  logic [2*WIDTH-1:0] rdata;
  logic [LW-1:0]      level;

  // The first edge after reset only captures a baseline; no event can fire yet.
  assign chg_event   = primed_q && (bus.a != prev_q);
  assign entry.value = bus.a;
  assign entry.mask  = change_pkg::toggle_mask(bus.a, prev_q);
  assign pop         = bus.out_ready && !empty;
  assign drop        = chg_event && full && !pop;

  sync_fifo #(
    .DEPTH(DEPTH),
    .DW   (2*WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (chg_event),
    .pop_i  (pop),
    .wdata_i(entry),
    .rdata_o(rdata),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  always_comb begin
    prev_d   = bus.a;
    primed_d = 1'b1;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (chg_event && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.out_data   = rdata;
  assign bus.out_valid  = !empty;
  assign bus.change_cnt = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.level      = level;

endmodule
